mem_arbiter: RTL and testbench

Sequences a single-ported, fixed-latency RAM between the instruction-fetch port and the data port of the pipelined datapath. Each port raises a request, and the arbiter grants one port at a time. It holds the address and store data for the whole access and pulses completion to the requester on the final access cycle. Data has priority, and ports alternate when both are pending. The block sits between the cache/datapath request signals and the RAM model.

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: the machine word and the memory arbiter state encoding.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency RAM between the instruction-fetch port and the data
// port. One port is granted at a time. Its address and store data are captured
// at the grant, and completion is signalled in the last access cycle. A waiting
// data request wins over a waiting instruction request unless the previous
// completed access was also a data access, so continuous contention alternates.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned LAT = 2
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  iREN,
    input  word_t iaddr,
    output logic  iwait,
    output word_t iload,
    input  logic  dREN,
    input  logic  dWEN,
    input  word_t daddr,
    input  word_t dstore,
    output logic  dwait,
    output word_t dload,
    output logic  ramREN,
    output logic  ramWEN,
    output word_t ramaddr,
    output word_t ramstore,
    input  word_t ramload
);

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    arb_state_t r_state;
    logic [3:0] r_cnt;
    logic       r_lastD;

    logic w_dReq;
    logic w_grantReq;

    assign w_dReq     = dREN | dWEN;
    assign w_grantReq = (r_state == IACC) ? iREN : w_dReq;

    // Grant, count down the access latency, then complete or abort back to IDLE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_lastD  <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_dReq && (!iREN || !r_lastD)) begin
                        r_state  <= DACC;
                        r_cnt    <= CNT_INIT;
                        ramaddr  <= daddr;
                        ramstore <= dstore;
                    end else if (iREN) begin
                        r_state <= IACC;
                        r_cnt   <= CNT_INIT;
                        ramaddr <= iaddr;
                    end
                end
                IACC, DACC: begin
                    if (!w_grantReq) begin
                        r_state <= IDLE;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= IDLE;
                        r_lastD <= (r_state == DACC);
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // RAM strobes follow the granted port; wait drops and load passes through on the final cycle.
    always_comb begin
        iwait  = iREN;
        dwait  = w_dReq;
        iload  = '0;
        dload  = '0;
        ramREN = 1'b0;
        ramWEN = 1'b0;
        case (r_state)
            IACC: begin
                ramREN = 1'b1;
                if ((r_cnt == 4'd0) && iREN) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            DACC: begin
                ramREN = dREN;
                ramWEN = dWEN;
                if ((r_cnt == 4'd0) && w_dReq) begin
                    dwait = 1'b0;
                    dload = ramload;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single reads at LAT=2 and LAT=1,
// contention ordering, alternation with write-back, abort and mid-access reset.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic  CLK;
    logic  RST;
    logic  iREN;
    logic  dREN;
    logic  dWEN;
    word_t iaddr;
    word_t daddr;
    word_t dstore;

    logic  iwait;
    logic  dwait;
    word_t iload;
    word_t dload;
    logic  ramREN;
    logic  ramWEN;
    word_t ramaddr;
    word_t ramstore;
    word_t ramload;

    logic  iwait1;
    logic  dwait1;
    word_t iload1;
    word_t dload1;
    logic  ramREN1;
    logic  ramWEN1;
    word_t ramaddr1;
    word_t ramstore1;
    word_t ramload1;

    word_t mem [0:1023];

    int assertCount = 0;
    int failCount   = 0;

    mem_arbiter #(.LAT(2)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload)
    );

    mem_arbiter #(.LAT(1)) dutLat1 (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait1), .iload(iload1),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait1), .dload(dload1),
        .ramREN(ramREN1), .ramWEN(ramWEN1), .ramaddr(ramaddr1),
        .ramstore(ramstore1), .ramload(ramload1)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Word-addressed RAM model; only the LAT=2 instance writes it.
    assign ramload  = mem[ramaddr[11:2]];
    assign ramload1 = mem[ramaddr1[11:2]];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem['h40  >> 2] = 32'h8C22_0004;
        mem['h100 >> 2] = 32'h1111_1111;
        mem['h000 >> 2] = 32'h2222_2222;
        forever begin
            @(posedge CLK);
            if (ramWEN) mem[ramaddr[11:2]] <= ramstore;
        end
    end

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive all request inputs, then let combinational outputs settle.
    task automatic applyStimulus(input logic ir, input word_t ia, input logic dr,
                                 input logic dw, input word_t da, input word_t ds);
        iREN   = ir;
        iaddr  = ia;
        dREN   = dr;
        dWEN   = dw;
        daddr  = da;
        dstore = ds;
        #1;
    endtask

    task automatic nextCycle();
        @(negedge CLK);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset with an instruction request already raised
        RST = 1'b1;
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("rst_iwait",   32'(iwait),    32'h1);
        checkOutput("rst_dwait",   32'(dwait),    32'h0);
        checkOutput("rst_ramREN",  32'(ramREN),   32'h0);
        checkOutput("rst_ramWEN",  32'(ramWEN),   32'h0);
        checkOutput("rst_ramaddr", ramaddr,       32'h0);
        checkOutput("rst_iload",   iload,         32'h0);

        // Instruction read, LAT=2 (and LAT=1 in parallel)
        nextCycle(); RST = 1'b0; #1;
        checkOutput("ird_c0_state",  32'(dut.r_state), 32'(IDLE));
        checkOutput("ird_c0_iwait",  32'(iwait),       32'h1);
        checkOutput("lat1_c0_iwait", 32'(iwait1),      32'h1);
        nextCycle();
        checkOutput("ird_c1_iwait",   32'(iwait),  32'h1);
        checkOutput("ird_c1_ramREN",  32'(ramREN), 32'h1);
        checkOutput("ird_c1_ramaddr", ramaddr,     32'h40);
        checkOutput("lat1_c1_iwait",  32'(iwait1), 32'h0);
        checkOutput("lat1_c1_iload",  iload1,      32'h8C22_0004);
        nextCycle();
        checkOutput("ird_c2_iwait",   32'(iwait), 32'h0);
        checkOutput("ird_c2_iload",   iload,      32'h8C22_0004);
        checkOutput("ird_c2_ramaddr", ramaddr,    32'h40);
        nextCycle();
        checkOutput("ird_c3_state", 32'(dut.r_state), 32'(IDLE));
        checkOutput("ird_c3_iwait", 32'(iwait),       32'h1);
        checkOutput("ird_c3_iload", iload,            32'h0);
        checkOutput("ird_c3_lastD", 32'(dut.r_lastD), 32'h0);
        applyStimulus(1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);

        // Contention from reset: data first, one idle cycle, then instruction
        nextCycle(); RST = 1'b1;
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
        nextCycle(); RST = 1'b0; #1;
        checkOutput("con_c0_dwait", 32'(dwait), 32'h1);
        checkOutput("con_c0_iwait", 32'(iwait), 32'h1);
        nextCycle();
        checkOutput("con_c1_state",   32'(dut.r_state), 32'(DACC));
        checkOutput("con_c1_ramaddr", ramaddr,          32'h100);
        checkOutput("con_c1_dwait",   32'(dwait),       32'h1);
        nextCycle();
        checkOutput("con_c2_dwait", 32'(dwait), 32'h0);
        checkOutput("con_c2_dload", dload,      32'h1111_1111);
        checkOutput("con_c2_iwait", 32'(iwait), 32'h1);
        nextCycle();
        checkOutput("con_c3_state", 32'(dut.r_state), 32'(IDLE));
        checkOutput("con_c3_lastD", 32'(dut.r_lastD), 32'h1);
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h100, 32'h0);
        nextCycle();
        checkOutput("con_c4_state",   32'(dut.r_state), 32'(IACC));
        checkOutput("con_c4_ramaddr", ramaddr,          32'h0);
        checkOutput("con_c4_iwait",   32'(iwait),       32'h1);
        nextCycle();
        checkOutput("con_c5_iwait", 32'(iwait), 32'h0);
        checkOutput("con_c5_iload", iload,      32'h2222_2222);
        nextCycle();
        checkOutput("con_c6_lastD", 32'(dut.r_lastD), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Alternation: D, I, D, I with completions at cycles 2, 5, 8, 11
        nextCycle();
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) nextCycle();
            checkOutput($sformatf("alt_k%0d_dwait", k), 32'(dwait), 32'((k % 6) != 2));
            checkOutput($sformatf("alt_k%0d_iwait", k), 32'(iwait), 32'((k % 6) != 5));
            if ((k % 6) == 1) begin
                checkOutput($sformatf("alt_k%0d_ramWEN", k),   32'(ramWEN), 32'h1);
                checkOutput($sformatf("alt_k%0d_ramstore", k), ramstore,    32'hDEAD_BEEF);
            end
            if ((k % 6) == 4) checkOutput($sformatf("alt_k%0d_ramaddr", k), ramaddr, 32'h40);
            if ((k % 6) == 5) checkOutput($sformatf("alt_k%0d_iload", k), iload, 32'h8C22_0004);
        end
        nextCycle();
        checkOutput("alt_k12_state", 32'(dut.r_state), 32'(IDLE));
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
        nextCycle();
        nextCycle();
        checkOutput("rdbk_dwait", 32'(dwait), 32'h0);
        checkOutput("rdbk_dload", dload,      32'hDEAD_BEEF);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Abort: data read dropped after grant, pending instruction goes next
        nextCycle(); RST = 1'b1;
        applyStimulus(1'b0, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0);
        nextCycle(); RST = 1'b0; #1;
        checkOutput("abt_c0_dwait", 32'(dwait), 32'h1);
        nextCycle();
        checkOutput("abt_c1_state", 32'(dut.r_state), 32'(DACC));
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h100, 32'h0);
        checkOutput("abt_c1_dload",  dload,         32'h0);
        checkOutput("abt_c1_ramREN", 32'(ramREN),   32'h0);
        checkOutput("abt_c1_iwait",  32'(iwait),    32'h1);
        nextCycle();
        checkOutput("abt_c2_state", 32'(dut.r_state), 32'(IDLE));
        checkOutput("abt_c2_lastD", 32'(dut.r_lastD), 32'h0);
        checkOutput("abt_c2_dload", dload,            32'h0);
        nextCycle();
        checkOutput("abt_c3_state",   32'(dut.r_state), 32'(IACC));
        checkOutput("abt_c3_ramaddr", ramaddr,          32'h40);
        nextCycle();
        checkOutput("abt_c4_iwait", 32'(iwait), 32'h0);
        checkOutput("abt_c4_iload", iload,      32'h8C22_0004);

        // Reset in the middle of a data write
        nextCycle(); RST = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 32'h1234_5678);
        nextCycle(); RST = 1'b0; #1;
        nextCycle();
        checkOutput("mrst_pre_ramWEN",   32'(ramWEN), 32'h1);
        checkOutput("mrst_pre_ramaddr",  ramaddr,     32'h300);
        checkOutput("mrst_pre_ramstore", ramstore,    32'h1234_5678);
        RST = 1'b1; #1;
        checkOutput("mrst_ramWEN",   32'(ramWEN),       32'h0);
        checkOutput("mrst_state",    32'(dut.r_state),  32'(IDLE));
        checkOutput("mrst_ramaddr",  ramaddr,           32'h0);
        checkOutput("mrst_ramstore", ramstore,          32'h0);
        checkOutput("mrst_dwait",    32'(dwait),        32'h1);
        nextCycle(); RST = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        nextCycle();
        checkOutput("mrst_post_state",  32'(dut.r_state), 32'(IDLE));
        checkOutput("mrst_post_ramWEN", 32'(ramWEN),      32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
